vec_count_sched: RTL and testbench

Schedules increments for N independent W-bit counter channels that share a single incrementer.
- Requests come from external tick pulses or a built-in periodic timer.
- Requests are latched as pending and serviced one per cycle in round-robin order.
- The block also provides a synchronous load port, a combinational read port, per-channel change-event pulses and sticky wrap flags.
- It sits between tick sources and any logic that monitors counter values.

---
 rtl/vec_count_sched.sv | 125 ++++++++++++
 tb/tb_vec_count_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_count_sched.sv
// vec_count_sched: N counter channels share one incrementer.
// Each channel holds at most one pending increment request. Requests come
// from external tick pulses or from a shared periodic timer. Pending requests
// are granted one per cycle in round-robin order. The block also has a
// synchronous load port, a combinational read port, per-channel update pulses
// and sticky wrap flags.
module vec_count_sched #(
  parameter int N      = 4,
  parameter int W      = 5,
  parameter int PERIOD = 10,
  parameter int CW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  en,
  input  logic [N-1:0]  tick_req,
  input  logic          ld,
  input  logic [CW-1:0] ld_ch,
  input  logic [W-1:0]  ld_val,
  input  logic [CW-1:0] rd_ch,
  output logic [W-1:0]  rd_val,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  upd,
  output logic [N-1:0]  wrap,
  input  logic          clr_wrap,
  output logic          busy
);

  localparam int TW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PM1 = (PERIOD > 0) ? PERIOD - 1 : 0;

  logic [W-1:0]  cnt [N];
  logic [N-1:0]  pend;
  logic [CW-1:0] ptr;
  logic [TW-1:0] timer;
  logic          timer_fire;
  logic [N-1:0]  req;
  logic [N-1:0]  ld_mask;
  logic [N-1:0]  elig;
  logic [N-1:0]  wrap_set;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;

  // A PERIOD of zero leaves the timer parked at zero and never firing.
  assign timer_fire = (PERIOD != 0) && (timer == TW'(PM1));
  assign req        = en & (tick_req | {N{timer_fire}});
  assign busy       = |pend;

  // Decode the load channel. The decoded channel is masked out of arbitration
  // so that the load and the increment never collide on one counter.
  always_comb begin
    ld_mask = '0;
    if (ld) ld_mask = N'(1) << ld_ch;
    elig = pend & ~ld_mask;
  end

  // Round-robin search. Start at ptr and scan upward modulo N. Take the
  // first eligible channel.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int j = 0; j < N; j++) begin
      idx = (int'(ptr) + j) % N;
      if (!gnt_any && elig[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = CW'(idx);
      end
    end
  end

  // A wrap occurs when the granted counter is at all-ones.
  always_comb begin
    wrap_set = '0;
    for (int i = 0; i < N; i++) wrap_set[i] = gnt[i] & (&cnt[i]);
  end

  // Read mux. A channel select beyond N-1 reads as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(rd_ch) == i) rd_val = cnt[i];
    end
  end

  // Periodic timer counts 0..PERIOD-1 and then wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             timer <= '0;
    else if (timer_fire)    timer <= '0;
    else if (PERIOD != 0)   timer <= timer + 1'b1;
  end

  // Pending, pointer, update-pulse and sticky-wrap state.
  // A new request keeps pend set even if the channel is granted in the same
  // cycle. A low en clears pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ptr  <= '0;
      upd  <= '0;
      wrap <= '0;
    end else begin
      pend <= en & (req | (pend & ~gnt));
      upd  <= gnt | ld_mask;
      wrap <= (clr_wrap ? '0 : wrap) | wrap_set;
      if (gnt_any) ptr <= (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Counter array. A load and a grant never target the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ld_mask[i])  cnt[i] <= ld_val;
        else if (gnt[i]) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_count_sched.sv
// Directed bench for vec_count_sched.
// The first instance uses the periodic timer (PERIOD=10). The second instance
// has the timer disabled (PERIOD=0) and exercises ticks, loads, wrap, enable
// and reset behaviour.
module tb_vec_count_sched;

  logic       clk;
  logic       rst_n;

  logic [3:0] a_en, a_tick, a_gnt, a_upd, a_wrap;
  logic       a_ld, a_clr, a_busy;
  logic [1:0] a_ld_ch, a_rd_ch;
  logic [4:0] a_ld_val, a_rd_val;

  logic [3:0] b_en, b_tick, b_gnt, b_upd, b_wrap;
  logic       b_ld, b_clr, b_busy;
  logic [1:0] b_ld_ch, b_rd_ch;
  logic [4:0] b_ld_val, b_rd_val;

  int checks;
  int errors;

  vec_count_sched #(.N(4), .W(5), .PERIOD(10)) u_per (
    .clk(clk), .rst_n(rst_n), .en(a_en), .tick_req(a_tick),
    .ld(a_ld), .ld_ch(a_ld_ch), .ld_val(a_ld_val),
    .rd_ch(a_rd_ch), .rd_val(a_rd_val), .gnt(a_gnt), .upd(a_upd),
    .wrap(a_wrap), .clr_wrap(a_clr), .busy(a_busy)
  );

  vec_count_sched #(.N(4), .W(5), .PERIOD(0)) u_dir (
    .clk(clk), .rst_n(rst_n), .en(b_en), .tick_req(b_tick),
    .ld(b_ld), .ld_ch(b_ld_ch), .ld_val(b_ld_val),
    .rd_ch(b_rd_ch), .rd_val(b_rd_val), .gnt(b_gnt), .upd(b_upd),
    .wrap(b_wrap), .clr_wrap(b_clr), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd_a(input int ch, input logic [31:0] exp, input string tag);
    a_rd_ch = 2'(ch);
    #1;
    check(tag, 32'(a_rd_val), exp);
  endtask

  task automatic rd_b(input int ch, input logic [31:0] exp, input string tag);
    b_rd_ch = 2'(ch);
    #1;
    check(tag, 32'(b_rd_val), exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_en = 4'h0; a_tick = 4'h0; a_ld = 1'b0; a_ld_ch = 2'd0; a_ld_val = 5'd0;
    a_rd_ch = 2'd0; a_clr = 1'b0;
    b_en = 4'h0; b_tick = 4'h0; b_ld = 1'b0; b_ld_ch = 2'd0; b_ld_val = 5'd0;
    b_rd_ch = 2'd0; b_clr = 1'b0;

    // Check the outputs while reset is held.
    @(negedge clk); #1;
    check("rst_gnt",  32'(b_gnt),  0);
    check("rst_busy", 32'(b_busy), 0);
    check("rst_upd",  32'(b_upd),  0);
    check("rst_wrap", 32'(b_wrap), 0);
    rd_b(0, 0, "rst_rd");
    check("rst_busy_a", 32'(a_busy), 0);
    a_en = 4'hF;

    // Timer instance. Cycle 0 is the cycle in which reset is released.
    @(negedge clk); rst_n = 1'b1;
    repeat (9) @(negedge clk);
    #1 check("per_idle_c9", 32'(a_busy), 0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("per_gnt", 32'(a_gnt), 32'(1) << c);
      check("per_upd", 32'(a_upd), (c == 0) ? 0 : (32'(1) << (c - 1)));
      @(negedge clk);
    end
    #1;
    check("per_gnt_c14", 32'(a_gnt), 0);
    check("per_upd_c14", 32'(a_upd), 32'h8);
    for (int ch = 0; ch < 4; ch++) rd_a(ch, 1, "per_cnt1");
    repeat (91) @(negedge clk);
    for (int ch = 0; ch < 4; ch++) rd_a(ch, 10, "per_cnt10");

    // Timer-less instance: two ticks in one cycle, serviced in order.
    @(negedge clk);
    b_en = 4'hF; b_tick = 4'b1010;
    #1 check("tk_gnt0", 32'(b_gnt), 0);
    check("tk_busy0", 32'(b_busy), 0);
    @(negedge clk); b_tick = 4'h0;
    #1 check("tk_gnt1", 32'(b_gnt), 32'h2);
    check("tk_busy1", 32'(b_busy), 1);
    @(negedge clk);
    #1 check("tk_gnt2", 32'(b_gnt), 32'h8);
    check("tk_busy2", 32'(b_busy), 1);
    check("tk_upd2", 32'(b_upd), 32'h2);
    @(negedge clk);
    #1 check("tk_gnt3", 32'(b_gnt), 0);
    check("tk_busy3", 32'(b_busy), 0);
    check("tk_upd3", 32'(b_upd), 32'h8);
    rd_b(0, 0, "tk_ch0");
    rd_b(1, 1, "tk_ch1");
    rd_b(2, 0, "tk_ch2");
    rd_b(3, 1, "tk_ch3");

    // Wrap: load 31 into ch2, then tick it.
    @(negedge clk);
    b_ld = 1'b1; b_ld_ch = 2'd2; b_ld_val = 5'd31;
    @(negedge clk); b_ld = 1'b0; b_tick = 4'b0100;
    rd_b(2, 31, "wr_load");
    check("wr_ld_upd", 32'(b_upd), 32'h4);
    @(negedge clk); b_tick = 4'h0;
    #1 check("wr_gnt", 32'(b_gnt), 32'h4);
    @(negedge clk);
    rd_b(2, 0, "wr_cnt");
    check("wr_flag", 32'(b_wrap), 32'h4);
    check("wr_upd", 32'(b_upd), 32'h4);
    // A second wrap on the same edge as clr_wrap. The set must win.
    @(negedge clk);
    b_ld = 1'b1; b_ld_ch = 2'd2; b_ld_val = 5'd31;
    @(negedge clk); b_ld = 1'b0; b_tick = 4'b0100;
    @(negedge clk); b_tick = 4'h0; b_clr = 1'b1;
    #1 check("wr2_gnt", 32'(b_gnt), 32'h4);
    @(negedge clk); b_clr = 1'b0;
    #1 check("wr2_setwins", 32'(b_wrap), 32'h4);
    rd_b(2, 0, "wr2_cnt");
    b_clr = 1'b1;
    @(negedge clk); b_clr = 1'b0;
    #1 check("wr_clr", 32'(b_wrap), 0);

    // Load collision: ch1 is pending and is loaded with 7 in the same cycle.
    @(negedge clk); b_tick = 4'b0010;
    @(negedge clk); b_tick = 4'h0;
    b_ld = 1'b1; b_ld_ch = 2'd1; b_ld_val = 5'd7;
    #1 check("lc_gnt_masked", 32'(b_gnt), 0);
    check("lc_busy", 32'(b_busy), 1);
    @(negedge clk); b_ld = 1'b0;
    rd_b(1, 7, "lc_loaded");
    check("lc_upd1", 32'(b_upd), 32'h2);
    check("lc_gnt_later", 32'(b_gnt), 32'h2);
    @(negedge clk);
    rd_b(1, 8, "lc_incr");
    check("lc_upd2", 32'(b_upd), 32'h2);
    check("lc_idle", 32'(b_busy), 0);

    // Disable while pending. ptr is at 2, so ch0 waits behind ch2, ch3 and ch1.
    @(negedge clk); b_tick = 4'hF;
    @(negedge clk); b_tick = 4'h0;
    #1 check("dis_gnt2", 32'(b_gnt), 32'h4);
    b_en = 4'b1110;
    @(negedge clk); b_en = 4'hF;
    #1 check("dis_gnt3", 32'(b_gnt), 32'h8);
    @(negedge clk);
    #1 check("dis_skip0", 32'(b_gnt), 32'h2);
    @(negedge clk);
    #1 check("dis_busy", 32'(b_busy), 0);
    rd_b(0, 0, "dis_ch0");
    rd_b(1, 9, "dis_ch1");
    rd_b(2, 1, "dis_ch2");
    rd_b(3, 2, "dis_ch3");

    // Asynchronous reset in the middle of a burst with all four channels pending.
    @(negedge clk); b_tick = 4'hF;
    @(negedge clk); b_tick = 4'h0;
    #1 check("ar_busy_pre", 32'(b_busy), 1);
    check("ar_gnt_pre", 32'(b_gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1 check("ar_gnt", 32'(b_gnt), 0);
    check("ar_busy", 32'(b_busy), 0);
    check("ar_upd", 32'(b_upd), 0);
    check("ar_wrap", 32'(b_wrap), 0);
    rd_b(3, 0, "ar_rd");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("ar_nogrant", 32'(b_gnt), 0);
      check("ar_nobusy", 32'(b_busy), 0);
    end
    b_tick = 4'b0001;
    @(negedge clk); b_tick = 4'h0;
    #1 check("ar_new_gnt", 32'(b_gnt), 32'h1);
    @(negedge clk);
    rd_b(0, 1, "ar_new_cnt");
    check("ar_new_upd", 32'(b_upd), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
